// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong frame store at the FFT tail that replays each
// bit-reversed frame in natural order under a valid/ready handshake.
// Optional feature macro: FFT_OUT_SAT_EN narrows outputs to DATA-1 bits with
// symmetric saturation. Undefined, outputs keep DATA bits unchanged.
module fft_out_reorder #(
    parameter int unsigned DATA  = 13,
    parameter int unsigned ARRAY = 16,
    parameter int unsigned NPT   = 512,
`ifdef FFT_OUT_SAT_EN
    localparam int unsigned OW   = DATA - 1
`else
    localparam int unsigned OW   = DATA
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic [ARRAY-1:0][DATA-1:0]  din_re,
    input  logic [ARRAY-1:0][DATA-1:0]  din_im,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [ARRAY-1:0][OW-1:0]    dout_re,
    output logic [ARRAY-1:0][OW-1:0]    dout_im,
    output logic                        dout_last,
    output logic                        overflow
);

    localparam int unsigned LOG2N = $clog2(NPT);
    localparam int unsigned LOG2A = $clog2(ARRAY);
    localparam int unsigned BEATS = NPT / ARRAY;
    localparam int unsigned BW    = LOG2N - LOG2A;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

`ifdef FFT_OUT_SAT_EN
    localparam logic signed [DATA-1:0] SAT_MAX = DATA'(2 ** (OW - 1) - 1);
    localparam logic signed [DATA-1:0] SAT_MIN = -SAT_MAX;
`endif

    typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_e;

    // Frame storage: two banks, indexed by stored sample index k
    logic [DATA-1:0] mem_re_q [2][NPT];
    logic [DATA-1:0] mem_im_q [2][NPT];

    logic [1:0]      full_q, full_d;
    logic            wbank_q, wbank_d;
    logic [BW-1:0]   wbeat_q, wbeat_d;
    logic            overflow_q, overflow_d;
    logic            wr_acc_c;

    rd_state_e       state_q, state_d;
    logic            rbank_q, rbank_d;
    logic [BW-1:0]   rbeat_q, rbeat_d;
    logic            dout_valid_q, dout_valid_d;
    logic            dout_last_q, dout_last_d;
    logic            release_c;
    logic            ld_en_c;
    logic            ld_bank_c;
    logic [BW-1:0]   ld_beat_c;

    logic [ARRAY-1:0][OW-1:0] dout_re_q, dout_re_d;
    logic [ARRAY-1:0][OW-1:0] dout_im_q, dout_im_d;

    logic [LOG2N-1:0] nat_idx;
    logic [LOG2N-1:0] src_idx;
    logic [DATA-1:0]  src_re;
    logic [DATA-1:0]  src_im;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = x[LOG2N-1-i];
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] out_cast(input logic [DATA-1:0] x);
`ifdef FFT_OUT_SAT_EN
        if ($signed(x) > SAT_MAX) begin
            return OW'(SAT_MAX);
        end
        if ($signed(x) < SAT_MIN) begin
            return OW'(SAT_MIN);
        end
        return OW'(x);
`else
        return x;
`endif
    endfunction

    // Last-beat handshake frees the read bank in the same cycle
    assign release_c = (state_q == RD_DRAIN) && dout_valid_q && dout_ready
                       && (rbeat_q == LAST_BEAT);

    // Write side: accept into the write bank unless it is still full
    always_comb begin
        full_d     = full_q;
        wbank_d    = wbank_q;
        wbeat_d    = wbeat_q;
        overflow_d = overflow_q;
        wr_acc_c   = 1'b0;
        if (release_c) begin
            full_d[rbank_q] = 1'b0;
        end
        if (valid_in) begin
            if (full_d[wbank_q]) begin
                overflow_d = 1'b1;
            end else begin
                wr_acc_c = 1'b1;
                if (wbeat_q == LAST_BEAT) begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                    wbeat_d         = '0;
                end else begin
                    wbeat_d = wbeat_q + BW'(1);
                end
            end
        end
    end

    // Read FSM: pick which beat of which bank to load into the output register
    always_comb begin
        state_d      = state_q;
        rbank_d      = rbank_q;
        rbeat_d      = rbeat_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        ld_en_c      = 1'b0;
        ld_bank_c    = rbank_q;
        ld_beat_c    = rbeat_q;
        case (state_q)
            RD_IDLE: begin
                if (full_d[rbank_q]) begin
                    ld_en_c      = 1'b1;
                    ld_beat_c    = '0;
                    rbeat_d      = '0;
                    dout_valid_d = 1'b1;
                    state_d      = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (dout_valid_q && dout_ready) begin
                    if (rbeat_q == LAST_BEAT) begin
                        rbank_d = ~rbank_q;
                        rbeat_d = '0;
                        if (full_d[~rbank_q]) begin
                            ld_en_c   = 1'b1;
                            ld_bank_c = ~rbank_q;
                            ld_beat_c = '0;
                        end else begin
                            dout_valid_d = 1'b0;
                            state_d      = RD_IDLE;
                        end
                    end else begin
                        ld_en_c   = 1'b1;
                        ld_beat_c = rbeat_q + BW'(1);
                        rbeat_d   = rbeat_q + BW'(1);
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
        if (ld_en_c) begin
            dout_last_d = (ld_beat_c == LAST_BEAT);
        end else if (!dout_valid_d) begin
            dout_last_d = 1'b0;
        end
    end

    // Output data: bit-reversed gather, forwarding a sample written this same cycle
    always_comb begin
        dout_re_d = dout_re_q;
        dout_im_d = dout_im_q;
        nat_idx   = '0;
        src_idx   = '0;
        src_re    = '0;
        src_im    = '0;
        for (int j = 0; j < ARRAY; j++) begin
            nat_idx = {ld_beat_c, LOG2A'(j)};
            src_idx = bitrev(nat_idx);
            if (wr_acc_c && (wbank_q == ld_bank_c)
                && (wbeat_q == src_idx[LOG2N-1:LOG2A])) begin
                src_re = din_re[src_idx[LOG2A-1:0]];
                src_im = din_im[src_idx[LOG2A-1:0]];
            end else begin
                src_re = mem_re_q[ld_bank_c][src_idx];
                src_im = mem_im_q[ld_bank_c][src_idx];
            end
            if (ld_en_c) begin
                dout_re_d[j] = out_cast(src_re);
                dout_im_d[j] = out_cast(src_im);
            end
        end
    end

    // Sample storage: lane l of write beat b lands at index b*ARRAY + l
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_c) begin
            for (int l = 0; l < ARRAY; l++) begin
                mem_re_q[wbank_q][{wbeat_q, LOG2A'(l)}] <= din_re[l];
                mem_im_q[wbank_q][{wbeat_q, LOG2A'(l)}] <= din_im[l];
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q       <= '0;
            wbank_q      <= 1'b0;
            wbeat_q      <= '0;
            overflow_q   <= 1'b0;
            state_q      <= RD_IDLE;
            rbank_q      <= 1'b0;
            rbeat_q      <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_re_q    <= '0;
            dout_im_q    <= '0;
        end else begin
            full_q       <= full_d;
            wbank_q      <= wbank_d;
            wbeat_q      <= wbeat_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            rbank_q      <= rbank_d;
            rbeat_q      <= rbeat_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            dout_re_q    <= dout_re_d;
            dout_im_q    <= dout_im_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign dout_re    = dout_re_q;
    assign dout_im    = dout_im_q;
    assign overflow   = overflow_q;

endmodule
